// File: rtl/key_state_tracker.sv
// -----------------------------------------------------------------------------
// key_state_tracker
//
// Tracks whether each of the NUM_KEYS piano keys (one octave, C..B = 0..11)
// is currently playing. Press/release events arrive from the note-event
// front end over a valid/ready handshake. After a release, a key stays
// "playing" for HOLD_CYCLES more cycles so that very short notes are still
// visible on screen. The renderer performs a same-cycle lookup of one key.
// The voice allocator and the status LEDs use the full mask and the active
// count.
//
// Each key has a small OFF / ON / HOLD state machine and a HOLD_WIDTH-bit
// countdown counter.
//
// Ports
//   clk             system clock, all state on the rising edge
//   reset_n         asynchronous active-low reset
//   ev_valid        event present
//   ev_ready        event accepted this cycle (reset_n & ~clear_all)
//   ev_key[4:0]     key index of the event
//   ev_press        1 = press, 0 = release
//   clear_all       synchronous panic: all keys off, no event accepted
//   bad_key         one-cycle pulse after accepting an out-of-range key
//   key_requested   key index queried by the renderer
//   is_key_playing  combinational lookup of key_requested (0 if out of range)
//   playing_mask    bit k set while key k is not OFF
//   active_count    popcount of playing_mask, one cycle behind the mask
// -----------------------------------------------------------------------------
module key_state_tracker #(
  parameter int NUM_KEYS    = 12,      // at most 15 so active_count fits 4 bits
  parameter int HOLD_CYCLES = 500000,  // 0 = no hold after release
  parameter int HOLD_WIDTH  = 20       // HOLD_CYCLES < 2**HOLD_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [4:0]          ev_key,
  input  logic                ev_press,
  input  logic                clear_all,
  output logic                bad_key,
  input  logic [4:0]          key_requested,
  output logic                is_key_playing,
  output logic [NUM_KEYS-1:0] playing_mask,
  output logic [3:0]          active_count
);

  typedef enum logic [1:0] {
    KEY_OFF  = 2'd0,
    KEY_ON   = 2'd1,
    KEY_HOLD = 2'd2
  } key_state_e;

  // A release loads HOLD_CYCLES-1. The HOLD state then shows the key for
  // exactly HOLD_CYCLES edges, counting the accepting edge.
  localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD =
    HOLD_WIDTH'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

  key_state_e            state_q [NUM_KEYS];
  key_state_e            state_d [NUM_KEYS];
  logic [HOLD_WIDTH-1:0] cnt_q   [NUM_KEYS];
  logic [HOLD_WIDTH-1:0] cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0]   mask_q, mask_d;
  logic [3:0]            count_q;
  logic                  bad_key_q;

  logic                  ev_accept;
  logic                  ev_in_range;
  logic [NUM_KEYS-1:0]   ev_hit;
  logic [31:0]           mask_ext;

  function automatic logic [3:0] popcount(input logic [NUM_KEYS-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      c = c + 4'(m[i]);
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and event decode
  // --------------------------------------------------------------------------
  assign ev_ready    = reset_n & ~clear_all;
  assign ev_accept   = ev_valid & ev_ready;
  assign ev_in_range = (int'(ev_key) < NUM_KEYS);

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      ev_hit[k] = ev_accept & ev_in_range & (ev_key == 5'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Per-key next state
  // --------------------------------------------------------------------------
  // NOTE: every output of this block is given its default (hold current value)
  // before any branch. Any path that leaves a signal unassigned would infer a
  // latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (clear_all) begin
        state_d[k] = KEY_OFF;
        cnt_d[k]   = '0;
      end else begin
        unique case (state_q[k])
          KEY_OFF: begin
            if (ev_hit[k] && ev_press) state_d[k] = KEY_ON;
          end
          KEY_ON: begin
            if (ev_hit[k] && !ev_press) begin
              if (HOLD_CYCLES == 0) begin
                state_d[k] = KEY_OFF;
              end else begin
                state_d[k] = KEY_HOLD;
                cnt_d[k]   = HOLD_LOAD;
              end
            end
          end
          KEY_HOLD: begin
            // A press wins over expiry. A repeated release does not restart
            // the countdown. It behaves the same as no event.
            if (ev_hit[k] && ev_press) begin
              state_d[k] = KEY_ON;
              cnt_d[k]   = '0;
            end else if (cnt_q[k] == '0) begin
              state_d[k] = KEY_OFF;
            end else begin
              cnt_d[k] = cnt_q[k] - HOLD_WIDTH'(1);
            end
          end
          default: begin
            state_d[k] = KEY_OFF;
            cnt_d[k]   = '0;
          end
        endcase
      end
      mask_d[k] = (state_d[k] != KEY_OFF);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every edge-
  // triggered block then samples pre-edge values, whatever order they run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= KEY_OFF;
        cnt_q[k]   <= '0;
      end
      mask_q    <= '0;
      count_q   <= '0;
      bad_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      count_q   <= popcount(mask_q);
      bad_key_q <= ev_accept & ~ev_in_range;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Zero-extend the mask over the full 5-bit index space. Queries at or beyond
  // NUM_KEYS then read 0 without a separate range check.
  assign mask_ext       = 32'(mask_q);
  assign is_key_playing = mask_ext[key_requested];
  assign playing_mask   = mask_q;
  assign active_count   = count_q;
  assign bad_key        = bad_key_q;

endmodule

// File: tb/tb_key_state_tracker.sv
// -----------------------------------------------------------------------------
// Directed testbench for key_state_tracker.
// u_dut uses HOLD_CYCLES = 4. u_dut0 uses HOLD_CYCLES = 0 and shares every
// input with u_dut.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_key_state_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ev_valid;
  logic [4:0]  ev_key;
  logic        ev_press;
  logic        clear_all;
  logic [4:0]  key_requested;

  logic        ev_ready,  ev_ready0;
  logic        bad_key,   bad_key0;
  logic        playing,   playing0;
  logic [11:0] mask,      mask0;
  logic [3:0]  count,     count0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_state_tracker #(.NUM_KEYS(12), .HOLD_CYCLES(4), .HOLD_WIDTH(20)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_key         (ev_key),
    .ev_press       (ev_press),
    .clear_all      (clear_all),
    .bad_key        (bad_key),
    .key_requested  (key_requested),
    .is_key_playing (playing),
    .playing_mask   (mask),
    .active_count   (count)
  );

  key_state_tracker #(.NUM_KEYS(12), .HOLD_CYCLES(0), .HOLD_WIDTH(20)) u_dut0 (
    .clk            (clk),
    .reset_n        (reset_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready0),
    .ev_key         (ev_key),
    .ev_press       (ev_press),
    .clear_all      (clear_all),
    .bad_key        (bad_key0),
    .key_requested  (key_requested),
    .is_key_playing (playing0),
    .playing_mask   (mask0),
    .active_count   (count0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] key, input logic press);
    ev_valid = 1'b1;
    ev_key   = key;
    ev_press = press;
    step();
    ev_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    ev_valid      = 1'b0;
    ev_key        = '0;
    ev_press      = 1'b0;
    clear_all     = 1'b0;
    key_requested = '0;

    // ---- 1. reset state and lookup sweep ----
    repeat (3) step();
    check("rst_mask",  mask,     12'h000);
    check("rst_count", count,    4'd0);
    check("rst_bad",   bad_key,  1'b0);
    check("rst_ready", ev_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    check("ready_after_rst", ev_ready, 1'b1);
    for (int i = 0; i < 32; i++) begin
      key_requested = 5'(i);
      #1;
      check($sformatf("sweep_%0d", i), playing, 1'b0);
    end

    // ---- 2. press key 3 ----
    send(5'd3, 1'b1);                              // E0
    check("press3_mask",    mask,  12'h008);
    check("press3_count_E0", count, 4'd0);         // count lags mask
    step();                                        // E1
    check("press3_count_E1", count, 4'd1);
    key_requested = 5'd3; #1;
    check("lookup3", playing, 1'b1);
    key_requested = 5'd4; #1;
    check("lookup4", playing, 1'b0);

    // ---- 3. release key 3: visible for exactly 4 edges ----
    send(5'd3, 1'b0);                              // E0
    check("hold_E0", mask[3], 1'b1);
    step(); check("hold_E1", mask[3], 1'b1);
    step(); check("hold_E2", mask[3], 1'b1);
    step(); check("hold_E3", mask[3], 1'b1);
    step(); check("hold_E4", mask[3], 1'b0);

    // Press, release, then press again at E2 while in HOLD -> back to ON
    send(5'd3, 1'b1);
    send(5'd3, 1'b0);                              // E0
    step();                                        // E1
    send(5'd3, 1'b1);                              // E2
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("repress_on_%0d", i), mask[3], 1'b1);
    end

    // A second release during HOLD must not restart the countdown
    send(5'd3, 1'b0);                              // E0
    send(5'd3, 1'b0);                              // E1
    step();                                        // E2
    step(); check("rerel_E3", mask[3], 1'b1);      // E3
    step(); check("rerel_E4", mask[3], 1'b0);      // E4

    // ---- 4. press 0, 5, 11 then clear_all with a pending event ----
    send(5'd0, 1'b1);
    send(5'd5, 1'b1);
    send(5'd11, 1'b1);
    check("three_keys", mask, 12'h821);
    step();
    check("three_count", count, 4'd3);
    clear_all = 1'b1;
    ev_valid  = 1'b1;
    ev_key    = 5'd7;
    ev_press  = 1'b1;
    #1;
    check("clear_ready", ev_ready, 1'b0);
    step();
    check("clear_mask", mask, 12'h000);
    step();                                        // clear held a second cycle
    check("clear_hold_mask", mask, 12'h000);
    clear_all = 1'b0;
    #1;
    check("after_clear_ready", ev_ready, 1'b1);
    check("key7_not_yet", mask[7], 1'b0);
    step();                                        // event re-presented, accepted
    ev_valid = 1'b0;
    check("key7_set", mask, 12'h080);

    // ---- 5. out-of-range events ----
    send(5'd12, 1'b1);
    check("bad12_pulse", bad_key, 1'b1);
    check("bad12_mask",  mask,    12'h080);
    send(5'd31, 1'b1);
    check("bad31_pulse", bad_key, 1'b1);
    check("bad31_mask",  mask,    12'h080);
    step();
    check("bad_clear",   bad_key, 1'b0);
    key_requested = 5'd15; #1;
    check("lookup15", playing, 1'b0);
    key_requested = 5'd7; #1;
    check("lookup7", playing, 1'b1);

    // ---- 6. HOLD_CYCLES = 0 build, and reset mid-hold ----
    send(5'd9, 1'b1);
    check("h0_press9", mask0[9], 1'b1);
    send(5'd9, 1'b0);
    check("h0_release9",  mask0[9], 1'b0);
    check("h4_holding9",  mask[9],  1'b1);
    #2;                                            // away from any edge
    reset_n = 1'b0;
    #1;
    check("async_rst_mask",  mask,     12'h000);
    check("async_rst_mask0", mask0,    12'h000);
    check("async_rst_count", count,    4'd0);
    check("async_rst_ready", ev_ready, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    check("no_hold_survives", mask, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
